// File: rtl/ysyx_25070198_bus_pkg.sv
// Shared encodings for the IFU/LSU SimpleBus arbiter.
package ysyx_25070198_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } bus_state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } bus_owner_e;

  // Data returned to the owner when the slave never answers.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/ysyx_25070198_rr_sel.sv
// Two-way master selector: fixed LSU priority or round-robin on last owner.
module ysyx_25070198_rr_sel
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int LSU_PRIO = 1
) (
  input  logic       i_ifu_valid,
  input  logic       i_lsu_valid,
  input  bus_owner_e i_last_owner,
  output logic       o_sel_valid,
  output bus_owner_e o_sel_owner
);

  // Pick the winner among the currently requesting masters.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_sel_valid = i_ifu_valid | i_lsu_valid;
    o_sel_owner = OWN_IFU;
    if (i_lsu_valid && !i_ifu_valid) begin
      o_sel_owner = OWN_LSU;
    end else if (i_lsu_valid && i_ifu_valid) begin
      if (LSU_PRIO != 0) begin
        o_sel_owner = OWN_LSU;
      end else begin
        o_sel_owner = (i_last_owner == OWN_IFU) ? OWN_LSU : OWN_IFU;
      end
    end
  end

endmodule

// File: rtl/ysyx_25070198_bus_arbiter.sv
// Shares the single memory port between IFU and LSU, one transaction at a time.
module ysyx_25070198_bus_arbiter
  import ysyx_25070198_bus_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LSU_PRIO = 1,
  parameter int TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_wen,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  input  logic [3:0]        lsu_req_wmask,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_wen,
  output logic [DATA_W-1:0] mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_req_ready,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic              busy,
  output logic              timeout_err
);

  bus_state_e        r_state;
  bus_state_e        w_state_next;
  bus_owner_e        r_owner;
  logic [15:0]       r_cnt;
  logic              r_timeout_err;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wmask;
  logic              r_ifu_resp_valid;
  logic [DATA_W-1:0] r_ifu_resp_data;
  logic              r_lsu_resp_valid;
  logic [DATA_W-1:0] r_lsu_resp_data;

  logic              w_sel_valid;
  bus_owner_e        w_sel_owner;
  logic              w_hs;
  logic              w_in_flight;
  logic [15:0]       w_cnt_inc;
  logic              w_resp_ok;
  logic              w_timeout;
  logic [DATA_W-1:0] w_resp_data;

  ysyx_25070198_rr_sel #(
    .LSU_PRIO(LSU_PRIO)
  ) u_sel (
    .i_ifu_valid (ifu_req_valid),
    .i_lsu_valid (lsu_req_valid),
    .i_last_owner(r_owner),
    .o_sel_valid (w_sel_valid),
    .o_sel_owner (w_sel_owner)
  );

  // Ready goes only to the selected master, so any selection in IDLE is a handshake.
  assign w_hs        = (r_state == IDLE) && w_sel_valid;
  assign w_in_flight = (r_state == REQ) || (r_state == RESP);
  assign w_cnt_inc   = r_cnt + 16'd1;
  // Spurious responses outside RESP are dropped here.
  assign w_resp_ok   = (r_state == RESP) && mem_resp_valid;
  // A real response arriving on the last allowed cycle beats the timeout.
  assign w_timeout   = w_in_flight && !w_resp_ok && (w_cnt_inc == 16'(TIMEOUT));
  assign w_resp_data = w_timeout ? DATA_W'(TIMEOUT_DATA)
                     : ((r_owner == OWN_LSU) && r_wen) ? '0 : mem_resp_data;

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next  = r_state;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    mem_req_valid = 1'b0;
    busy          = 1'b0;
    case (r_state)
      IDLE: begin
        ifu_req_ready = w_sel_valid && (w_sel_owner == OWN_IFU);
        lsu_req_ready = w_sel_valid && (w_sel_owner == OWN_LSU);
        if (w_sel_valid) w_state_next = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        busy          = 1'b1;
        if (w_timeout)          w_state_next = IDLE;
        else if (mem_req_ready) w_state_next = RESP;
      end
      RESP: begin
        busy = 1'b1;
        if (w_resp_ok || w_timeout) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_next;
  end

  // Request latch, timeout counter and registered response pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner          <= OWN_IFU;
      r_cnt            <= '0;
      r_timeout_err    <= 1'b0;
      r_addr           <= '0;
      r_wen            <= 1'b0;
      r_wdata          <= '0;
      r_wmask          <= '0;
      r_ifu_resp_valid <= 1'b0;
      r_ifu_resp_data  <= '0;
      r_lsu_resp_valid <= 1'b0;
      r_lsu_resp_data  <= '0;
    end else begin
      r_ifu_resp_valid <= 1'b0;
      r_lsu_resp_valid <= 1'b0;
      if (w_hs) begin
        r_owner <= w_sel_owner;
        r_cnt   <= '0;
        if (w_sel_owner == OWN_LSU) begin
          r_addr  <= lsu_req_addr;
          r_wen   <= lsu_req_wen;
          r_wdata <= lsu_req_wdata;
          r_wmask <= lsu_req_wmask;
        end else begin
          r_addr  <= ifu_req_addr;
          r_wen   <= 1'b0;
          r_wdata <= '0;
          r_wmask <= '0;
        end
      end else if (w_in_flight) begin
        r_cnt <= w_cnt_inc;
      end
      if (w_resp_ok || w_timeout) begin
        if (r_owner == OWN_LSU) begin
          r_lsu_resp_valid <= 1'b1;
          r_lsu_resp_data  <= w_resp_data;
        end else begin
          r_ifu_resp_valid <= 1'b1;
          r_ifu_resp_data  <= w_resp_data;
        end
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign mem_req_addr   = r_addr;
  assign mem_req_wen    = r_wen;
  assign mem_req_wdata  = r_wdata;
  assign mem_req_wmask  = r_wmask;
  assign ifu_resp_valid = r_ifu_resp_valid;
  assign ifu_resp_data  = r_ifu_resp_data;
  assign lsu_resp_valid = r_lsu_resp_valid;
  assign lsu_resp_data  = r_lsu_resp_data;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_ysyx_25070198_bus_arbiter.sv
// Directed bench: instance 0 uses fixed LSU priority, instance 1 round-robin; both TIMEOUT=8.
module tb_ysyx_25070198_bus_arbiter;

  localparam int K_IFU_HS  = 0;
  localparam int K_LSU_HS  = 1;
  localparam int K_IFU_RSP = 2;
  localparam int K_LSU_RSP = 3;

  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] data;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        ifu_req_valid [2];
  logic [31:0] ifu_req_addr  [2];
  logic        ifu_req_ready [2];
  logic        ifu_resp_valid[2];
  logic [31:0] ifu_resp_data [2];
  logic        lsu_req_valid [2];
  logic [31:0] lsu_req_addr  [2];
  logic        lsu_req_wen   [2];
  logic [31:0] lsu_req_wdata [2];
  logic [3:0]  lsu_req_wmask [2];
  logic        lsu_req_ready [2];
  logic        lsu_resp_valid[2];
  logic [31:0] lsu_resp_data [2];
  logic        mem_req_valid [2];
  logic [31:0] mem_req_addr  [2];
  logic        mem_req_wen   [2];
  logic [31:0] mem_req_wdata [2];
  logic [3:0]  mem_req_wmask [2];
  logic        mem_req_ready [2];
  logic        mem_resp_valid[2] = '{1'b0, 1'b0};
  logic [31:0] mem_resp_data [2] = '{32'd0, 32'd0};
  logic        busy          [2];
  logic        timeout_err   [2];

  // Slave model configuration and state (not affected by rst).
  int          cfg_wait   [2];
  int          cfg_delay  [2];
  logic        cfg_respond[2];
  logic [31:0] cfg_rdata  [2];
  int          s_wait     [2] = '{0, 0};
  int          s_rcnt     [2] = '{0, 0};
  logic        s_pend     [2] = '{1'b0, 1'b0};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ysyx_25070198_bus_arbiter #(
      .ADDR_W(32), .DATA_W(32), .LSU_PRIO(g == 0 ? 1 : 0), .TIMEOUT(8)
    ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req_valid (ifu_req_valid[g]),
      .ifu_req_addr  (ifu_req_addr[g]),
      .ifu_req_ready (ifu_req_ready[g]),
      .ifu_resp_valid(ifu_resp_valid[g]),
      .ifu_resp_data (ifu_resp_data[g]),
      .lsu_req_valid (lsu_req_valid[g]),
      .lsu_req_addr  (lsu_req_addr[g]),
      .lsu_req_wen   (lsu_req_wen[g]),
      .lsu_req_wdata (lsu_req_wdata[g]),
      .lsu_req_wmask (lsu_req_wmask[g]),
      .lsu_req_ready (lsu_req_ready[g]),
      .lsu_resp_valid(lsu_resp_valid[g]),
      .lsu_resp_data (lsu_resp_data[g]),
      .mem_req_valid (mem_req_valid[g]),
      .mem_req_addr  (mem_req_addr[g]),
      .mem_req_wen   (mem_req_wen[g]),
      .mem_req_wdata (mem_req_wdata[g]),
      .mem_req_wmask (mem_req_wmask[g]),
      .mem_req_ready (mem_req_ready[g]),
      .mem_resp_valid(mem_resp_valid[g]),
      .mem_resp_data (mem_resp_data[g]),
      .busy          (busy[g]),
      .timeout_err   (timeout_err[g])
    );
  end

  // Slave accepts after cfg_wait stalled cycles.
  always_comb begin
    for (int k = 0; k < 2; k++)
      mem_req_ready[k] = mem_req_valid[k] && (s_wait[k] >= cfg_wait[k]);
  end

  // Slave answers cfg_delay cycles after the accepted request (0 = next cycle).
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      mem_resp_valid[k] <= 1'b0;
      if (mem_req_valid[k] && !mem_req_ready[k]) s_wait[k] <= s_wait[k] + 1;
      else                                      s_wait[k] <= 0;
      if (mem_req_valid[k] && mem_req_ready[k] && cfg_respond[k]) begin
        if (cfg_delay[k] == 0) begin
          mem_resp_valid[k] <= 1'b1;
          mem_resp_data[k]  <= cfg_rdata[k];
        end else begin
          s_pend[k] <= 1'b1;
          s_rcnt[k] <= cfg_delay[k];
        end
      end else if (s_pend[k]) begin
        if (s_rcnt[k] == 1) begin
          mem_resp_valid[k] <= 1'b1;
          mem_resp_data[k]  <= cfg_rdata[k];
          s_pend[k]         <= 1'b0;
        end else begin
          s_rcnt[k] <= s_rcnt[k] - 1;
        end
      end
    end
  end

  int   n_checks = 0;
  int   n_errors = 0;
  ev_t  log_q[$];
  logic hs_ifu[2] = '{1'b0, 1'b0};
  logic hs_lsu[2] = '{1'b0, 1'b0};

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic log_ev(int kind, logic [31:0] data);
    ev_t e;
    e.kind = kind;
    e.cyc  = cyc;
    e.data = data;
    log_q.push_back(e);
  endtask

  // Sample the current cycle, advance one clock, then retire accepted requests.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (ifu_resp_valid[k]) log_ev(K_IFU_RSP, ifu_resp_data[k]);
      if (lsu_resp_valid[k]) log_ev(K_LSU_RSP, lsu_resp_data[k]);
      if (ifu_req_valid[k] && ifu_req_ready[k]) begin
        hs_ifu[k] = 1'b1;
        log_ev(K_IFU_HS, ifu_req_addr[k]);
      end
      if (lsu_req_valid[k] && lsu_req_ready[k]) begin
        hs_lsu[k] = 1'b1;
        log_ev(K_LSU_HS, lsu_req_addr[k]);
      end
    end
    @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      if (hs_ifu[k]) begin ifu_req_valid[k] = 1'b0; hs_ifu[k] = 1'b0; end
      if (hs_lsu[k]) begin lsu_req_valid[k] = 1'b0; hs_lsu[k] = 1'b0; end
    end
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  task automatic exp_ev(string tag, int idx, int kind, int dcyc, logic [31:0] data);
    if (idx < log_q.size()) begin
      check({tag, ".kind"}, 32'(log_q[idx].kind), 32'(kind));
      check({tag, ".lat"}, 32'(log_q[idx].cyc - log_q[0].cyc), 32'(dcyc));
      check({tag, ".data"}, log_q[idx].data, data);
    end else begin
      check({tag, ".present"}, 32'(log_q.size()), 32'(idx + 1));
    end
  endtask

  task automatic lsu_req(int k, logic [31:0] addr, logic wen, logic [31:0] wdata, logic [3:0] wmask);
    lsu_req_valid[k] = 1'b1;
    lsu_req_addr[k]  = addr;
    lsu_req_wen[k]   = wen;
    lsu_req_wdata[k] = wdata;
    lsu_req_wmask[k] = wmask;
  endtask

  task automatic ifu_req(int k, logic [31:0] addr);
    ifu_req_valid[k] = 1'b1;
    ifu_req_addr[k]  = addr;
  endtask

  initial begin
    int n_req;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      ifu_req_valid[k] = 1'b0; ifu_req_addr[k]  = '0;
      lsu_req_valid[k] = 1'b0; lsu_req_addr[k]  = '0;
      lsu_req_wen[k]   = 1'b0; lsu_req_wdata[k] = '0; lsu_req_wmask[k] = '0;
      cfg_wait[k] = 0; cfg_delay[k] = 0; cfg_respond[k] = 1'b1; cfg_rdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst.busy", 32'(busy[0]), 32'd0);
    check("rst.mem_req_valid", 32'(mem_req_valid[0]), 32'd0);
    check("rst.ifu_resp_valid", 32'(ifu_resp_valid[0]), 32'd0);
    check("rst.lsu_resp_valid", 32'(lsu_resp_valid[0]), 32'd0);
    check("rst.timeout_err", 32'(timeout_err[0]), 32'd0);
    check("rst.mem_req_addr", mem_req_addr[0], 32'd0);
    rst = 1'b1;
    run(2);

    // IFU-only fetch, zero-wait slave.
    log_q.delete();
    cfg_rdata[0] = 32'h00100073;
    ifu_req(0, 32'h80000000);
    run(8);
    check("ifu_only.count", 32'(log_q.size()), 32'd2);
    exp_ev("ifu_only.hs", 0, K_IFU_HS, 0, 32'h80000000);
    exp_ev("ifu_only.rsp", 1, K_IFU_RSP, 3, 32'h00100073);

    // Contention with fixed LSU priority.
    log_q.delete();
    cfg_rdata[0] = 32'h11112222;
    ifu_req(0, 32'h80000004);
    lsu_req(0, 32'h80001000, 1'b0, 32'h0, 4'hf);
    run(12);
    check("prio.count", 32'(log_q.size()), 32'd4);
    exp_ev("prio.lsu_hs", 0, K_LSU_HS, 0, 32'h80001000);
    exp_ev("prio.lsu_rsp", 1, K_LSU_RSP, 3, 32'h11112222);
    exp_ev("prio.ifu_hs", 2, K_IFU_HS, 3, 32'h80000004);
    exp_ev("prio.ifu_rsp", 3, K_IFU_RSP, 6, 32'h11112222);

    // Round-robin, last owner IFU (from reset): LSU wins.
    log_q.delete();
    cfg_rdata[1] = 32'h33334444;
    ifu_req(1, 32'h80000008);
    lsu_req(1, 32'h80001004, 1'b0, 32'h0, 4'hf);
    run(12);
    check("rr_a.count", 32'(log_q.size()), 32'd4);
    exp_ev("rr_a.first", 0, K_LSU_HS, 0, 32'h80001004);
    exp_ev("rr_a.second", 2, K_IFU_HS, 3, 32'h80000008);

    // Make LSU the last owner, then contend again: IFU wins.
    lsu_req(1, 32'h80001008, 1'b0, 32'h0, 4'hf);
    run(6);
    log_q.delete();
    ifu_req(1, 32'h8000000c);
    lsu_req(1, 32'h8000100c, 1'b0, 32'h0, 4'hf);
    run(12);
    check("rr_b.count", 32'(log_q.size()), 32'd4);
    exp_ev("rr_b.first", 0, K_IFU_HS, 0, 32'h8000000c);
    exp_ev("rr_b.second", 2, K_LSU_HS, 3, 32'h8000100c);

    // LSU write with a slave stalling mem_req_ready for 4 cycles.
    log_q.delete();
    cfg_wait[0]  = 4;
    cfg_rdata[0] = 32'hffffffff;
    lsu_req(0, 32'h80002000, 1'b1, 32'h12345678, 4'b0011);
    n_req = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (mem_req_valid[0]) begin
        n_req++;
        check("wr.addr", mem_req_addr[0], 32'h80002000);
        check("wr.wen", 32'(mem_req_wen[0]), 32'd1);
        check("wr.wdata", mem_req_wdata[0], 32'h12345678);
        check("wr.wmask", 32'(mem_req_wmask[0]), 32'h3);
      end
    end
    cfg_wait[0] = 0;
    check("wr.req_cycles", 32'(n_req), 32'd5);
    check("wr.count", 32'(log_q.size()), 32'd2);
    exp_ev("wr.hs", 0, K_LSU_HS, 0, 32'h80002000);
    exp_ev("wr.rsp", 1, K_LSU_RSP, 7, 32'h0);

    // Slave never answers: forced completion after 8 in-flight cycles.
    log_q.delete();
    check("to.err_before", 32'(timeout_err[0]), 32'd0);
    cfg_respond[0] = 1'b0;
    lsu_req(0, 32'h80003000, 1'b0, 32'haaaa5555, 4'hf);
    run(12);
    check("to.count", 32'(log_q.size()), 32'd2);
    exp_ev("to.hs", 0, K_LSU_HS, 0, 32'h80003000);
    exp_ev("to.rsp", 1, K_LSU_RSP, 9, 32'hdeadbeef);
    check("to.err", 32'(timeout_err[0]), 32'd1);
    check("to.mem_req_valid", 32'(mem_req_valid[0]), 32'd0);
    check("to.busy", 32'(busy[0]), 32'd0);

    // Next request served normally; IFU grant clears write fields.
    log_q.delete();
    cfg_respond[0] = 1'b1;
    cfg_rdata[0]   = 32'hcafef00d;
    ifu_req(0, 32'h80000010);
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_req_valid[0]) begin
        check("after_to.wen", 32'(mem_req_wen[0]), 32'd0);
        check("after_to.wdata", mem_req_wdata[0], 32'd0);
        check("after_to.wmask", 32'(mem_req_wmask[0]), 32'd0);
      end
    end
    exp_ev("after_to.hs", 0, K_IFU_HS, 0, 32'h80000010);
    exp_ev("after_to.rsp", 1, K_IFU_RSP, 3, 32'hcafef00d);
    check("after_to.err_sticky", 32'(timeout_err[0]), 32'd1);

    // Reset while in RESP; the late slave response must be ignored.
    cfg_delay[0] = 3;
    ifu_req(0, 32'h80000014);
    step();
    step();
    check("rst_mid.busy_before", 32'(busy[0]), 32'd1);
    rst = 1'b0;
    step();
    check("rst_mid.busy", 32'(busy[0]), 32'd0);
    check("rst_mid.err", 32'(timeout_err[0]), 32'd0);
    check("rst_mid.mem_req_valid", 32'(mem_req_valid[0]), 32'd0);
    check("rst_mid.ifu_resp_valid", 32'(ifu_resp_valid[0]), 32'd0);
    rst = 1'b1;
    log_q.delete();
    run(6);
    check("rst_mid.no_pulse", 32'(log_q.size()), 32'd0);
    check("rst_mid.busy_after", 32'(busy[0]), 32'd0);
    cfg_delay[0] = 0;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
